simplecpu_wb_ctrl: RTL and testbench
====================================

Name: simplecpu_wb_ctrl

Overview:
Wishbone slave controller that sequences the simple CPU core from the management SoC. Owns the CPU reset, clock-enable and program-load port, replacing direct logic-analyzer driving of the core. Provides run/halt/single-step control, a program load pointer, a cycle counter and a halt interrupt. Sits in user_project_wrapper between the Wishbone slave port and the CPU instance.

Parameters:
BASE_ADDR, 32'h3000_0000, Wishbone base address; decode on wbs_adr_i[31:8] == BASE_ADDR[31:8].
PC_W, 8, CPU program counter and program address width.
PROG_W, 14, program word width.
RST_CYCLES, 4, number of cycles cpu_rst_o is held after reset or SOFT_RESET; must be at least 1.

Ports:
wb_clk_i  in  1  system clock; sole clock.
wb_rst_n_i  in  1  asynchronous, active-low reset.
wbs_stb_i  in  1  Wishbone strobe.
wbs_cyc_i  in  1  Wishbone cycle.
wbs_we_i  in  1  Wishbone write enable.
wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
wbs_adr_i  in  32  byte address; register select is bits [4:2].
wbs_dat_i  in  32  write data.
wbs_ack_o  out  1  acknowledge.
wbs_dat_o  out  32  read data.
cpu_rst_o  out  1  active-high reset to the CPU.
cpu_clk_en_o  out  1  CPU clock enable; the CPU advances one instruction per enabled cycle.
prog_we_o  out  1  program memory write strobe.
prog_addr_o  out  PC_W  program write address.
prog_data_o  out  PROG_W  program write data.
cpu_pc_i  in  PC_W  current CPU program counter.
cpu_halted_i  in  1  CPU has executed a HALT instruction.
irq_o  out  1  one-cycle pulse on every RUN->IDLE transition.

Behaviour:
- Reset (wb_rst_n_i low, asynchronous) forces:
  - outputs: wbs_ack_o=0, wbs_dat_o=0, cpu_rst_o=1, cpu_clk_en_o=0, prog_we_o=0, prog_addr_o=0, prog_data_o=0, irq_o=0;
  - internal: state=RST_HOLD, cycle counter=0, sticky ERR=0.
- Wishbone:
  - Decoded access = cyc&stb with a base match.
  - wbs_ack_o asserts exactly 1 cycle after a decoded access and lasts 1 cycle.
  - No ack is issued in the cycle after an ack, so one access completes per 2 cycles minimum.
  - Undecoded accesses are never acked.
  - Read data is registered with the ack. Reads of an unmapped offset return 0.
- Register map (offsets):
  - 0x00 CTRL, W: write-1 pulses; bit0 RUN, bit1 STEP, bit2 HALT, bit3 SOFT_RESET. Reads return 0.
  - 0x04 STATUS, R: [1:0] state (RST_HOLD=0, IDLE=1, RUN=2, STEP=3), [2] cpu_halted_i, [3] ERR, [4] BP_HIT, [15:8] cpu_pc_i (zero-extended).
  - 0x08 PROG, W: writes wbs_dat_i[PROG_W-1:0] at the load pointer, then increments the pointer.
  - 0x0C LOADPTR, RW: [PC_W-1:0].
  - 0x10 BREAKPOINT, RW: optional; see Optional Feature.
  - 0x14 CYCLES, R: count of cycles with cpu_clk_en_o=1. Any write clears it.
- FSM:
  - RST_HOLD: cpu_rst_o=1 for RST_CYCLES cycles, then IDLE.
  - IDLE: cpu_rst_o=0, cpu_clk_en_o=0.
    - RUN -> RUN.
    - STEP -> STEP.
    - HALT has no effect.
  - STEP: cpu_clk_en_o=1 for exactly one cycle, then IDLE. No irq_o.
  - RUN: cpu_clk_en_o=1.
    - Exits to IDLE on a HALT write, cpu_halted_i=1, or a breakpoint hit.
    - cpu_clk_en_o deasserts in the same cycle the state becomes IDLE.
    - irq_o pulses in that cycle.
- CTRL priority within one write: SOFT_RESET > HALT > RUN > STEP.
  - SOFT_RESET from any state: RST_HOLD; clears the cycle counter, ERR and BP_HIT; does not change LOADPTR.
  - RUN or STEP while cpu_halted_i=1: ignored, state stays IDLE.
  - STEP while in RUN: ignored.
- Program load:
  - A PROG write in IDLE or RST_HOLD pulses prog_we_o for 1 cycle, coincident with wbs_ack_o.
  - prog_addr_o = load pointer and prog_data_o = data, both held until the next load.
  - The pointer wraps from 2^PC_W-1 to 0.
  - A PROG write in RUN or STEP is acked but dropped; it sets ERR and does not advance the pointer.
- Cycle counter: 32 bits, saturates at 32'hFFFF_FFFF. A CYCLES write in the same cycle as an increment clears the counter (clear wins).

Optional Feature:
Macro SIMPLECPU_BREAKPOINT_EN.
- Defined:
  - Offset 0x10: [PC_W-1:0] BP_ADDR, [31] BP_ENA.
  - In RUN, when BP_ENA=1 and cpu_pc_i==BP_ADDR, the block leaves RUN before that instruction executes: cpu_clk_en_o is 0 that cycle, the state becomes IDLE, BP_HIT=1 and irq_o pulses.
  - A subsequent RUN from a PC equal to BP_ADDR executes at least one instruction before the breakpoint can hit again.
- Not defined: offset 0x10 reads 0 and ignores writes; BP_HIT is constant 0.

Test Plan:
- Release reset -> cpu_rst_o high for exactly 4 cycles, then STATUS reads 0x01 with cpu_pc_i in [15:8].
- Write LOADPTR=0xFE, then PROG 0x1ABC, 0x0123, 0x2222 -> prog_we_o pulses at addresses 0xFE, 0xFF, 0x00 with matching data; LOADPTR reads 0x01.
- CTRL=RUN, then cpu_halted_i high after 10 enabled cycles -> IDLE, irq_o single pulse, CYCLES=10.
- CTRL=0x6 (HALT|STEP) from IDLE -> no enabled cycle; CTRL=STEP -> exactly one enabled cycle, CYCLES increments by 1, no irq_o.
- PROG write during RUN -> acked, prog_we_o stays 0, STATUS[3]=1; SOFT_RESET -> ERR clears, RST_HOLD for 4 cycles.
- With SIMPLECPU_BREAKPOINT_EN: BP=0x80000005, RUN from PC 0 -> stops with PC=5, BP_HIT=1, irq_o pulse; RUN again -> PC advances past 5.

Source files
------------

// File: rtl/simplecpu_wb_ctrl_if.sv
// Wishbone slave bus bundle between the management SoC and simplecpu_wb_ctrl.
interface simplecpu_wb_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/simplecpu_wb_ctrl.sv
// Wishbone controller for the simple CPU: reset hold, run/halt/step, program load, cycle count, halt irq.
// Optional PC breakpoint enabled by defining SIMPLECPU_BREAKPOINT_EN.
module simplecpu_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          PC_W       = 8,
  parameter int          PROG_W     = 14,
  parameter int          RST_CYCLES = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  simplecpu_wb_ctrl_if.slave  wb,
  output logic                cpu_rst_o,
  output logic                cpu_clk_en_o,
  output logic                prog_we_o,
  output logic [PC_W-1:0]     prog_addr_o,
  output logic [PROG_W-1:0]   prog_data_o,
  input  logic [PC_W-1:0]     cpu_pc_i,
  input  logic                cpu_halted_i,
  output logic                irq_o
);
  typedef enum logic [1:0] {
    ST_RST_HOLD = 2'd0,
    ST_IDLE     = 2'd1,
    ST_RUN      = 2'd2,
    ST_STEP     = 2'd3
  } state_t;

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_rst_cnt;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_rst;
  logic                r_clk_en;
  logic                r_prog_we;
  logic [PC_W-1:0]     r_prog_addr;
  logic [PROG_W-1:0]   r_prog_data;
  logic                r_irq;
  logic [PC_W-1:0]     r_ptr;
  logic [31:0]         r_cycles;
  logic                r_err;

  logic                w_acc;
  logic                w_wr;
  logic                w_rd;
  logic [2:0]          w_off;
  logic                w_ctrl_wr;
  logic                w_soft;
  logic                w_bp_now;
  logic                w_bp_hit;
  logic                w_run_stop;
  logic [31:0]         w_bp_rd;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata;
  logic                w_unused;

  // No access is taken in the ack cycle, so a held strobe cannot be acked twice.
  assign w_acc     = wb.wbs_cyc_i & wb.wbs_stb_i & (wb.wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~r_ack;
  assign w_wr      = w_acc & wb.wbs_we_i;
  assign w_rd      = w_acc & ~wb.wbs_we_i;
  assign w_off     = wb.wbs_adr_i[4:2];
  assign w_ctrl_wr = w_wr & (w_off == 3'd0);
  assign w_soft    = w_ctrl_wr & wb.wbs_dat_i[3];
  assign w_unused  = ^{wb.wbs_sel_i, wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0], wb.wbs_dat_i};

`ifdef SIMPLECPU_BREAKPOINT_EN
  logic [PC_W-1:0] r_bp_addr;
  logic            r_bp_ena;
  logic            r_bp_skip;
  logic            r_bp_hit;

  assign w_bp_now = (r_state == ST_RUN) & r_bp_ena & ~r_bp_skip & (cpu_pc_i == r_bp_addr);
  assign w_bp_hit = r_bp_hit;
  always_comb begin
    w_bp_rd = '0;
    w_bp_rd[31] = r_bp_ena;
    w_bp_rd[PC_W-1:0] = r_bp_addr;
  end
`else
  assign w_bp_now = 1'b0;
  assign w_bp_hit = 1'b0;
  assign w_bp_rd  = 32'd0;
`endif

  // Gate the enable as soon as a stop condition appears so the CPU never runs past HALT or a breakpoint.
  assign w_run_stop   = (r_state == ST_RUN) & (cpu_halted_i | w_bp_now);
  assign cpu_clk_en_o = r_clk_en & ~w_run_stop;

  always_comb begin
    w_status = '0;
    w_status[1:0] = r_state;
    w_status[2] = cpu_halted_i;
    w_status[3] = r_err;
    w_status[4] = w_bp_hit;
    w_status[8 +: PC_W] = cpu_pc_i;
    w_rdata = '0;
    case (w_off)
      3'd1:    w_rdata = w_status;
      3'd3:    w_rdata[PC_W-1:0] = r_ptr;
      3'd4:    w_rdata = w_bp_rd;
      3'd5:    w_rdata = r_cycles;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= ST_RST_HOLD;
      r_rst_cnt   <= '0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_rst       <= 1'b1;
      r_clk_en    <= 1'b0;
      r_prog_we   <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_irq       <= 1'b0;
      r_ptr       <= '0;
      r_cycles    <= '0;
      r_err       <= 1'b0;
`ifdef SIMPLECPU_BREAKPOINT_EN
      r_bp_addr   <= '0;
      r_bp_ena    <= 1'b0;
      r_bp_skip   <= 1'b0;
      r_bp_hit    <= 1'b0;
`endif
    end else begin
      r_ack     <= w_acc;
      r_dat     <= w_rd ? w_rdata : '0;
      r_prog_we <= 1'b0;
      r_irq     <= 1'b0;

      if (w_soft || (w_wr && w_off == 3'd5)) begin
        r_cycles <= '0;
      end else if (cpu_clk_en_o && (r_cycles != '1)) begin
        r_cycles <= r_cycles + 32'd1;
      end

      if (w_wr && w_off == 3'd3) begin
        r_ptr <= wb.wbs_dat_i[PC_W-1:0];
      end

      // Loads while the CPU is clocked would race its fetches, so they are dropped and flagged.
      if (w_wr && w_off == 3'd2) begin
        if (r_state == ST_IDLE || r_state == ST_RST_HOLD) begin
          r_prog_we   <= 1'b1;
          r_prog_addr <= r_ptr;
          r_prog_data <= wb.wbs_dat_i[PROG_W-1:0];
          r_ptr       <= r_ptr + PC_W'(1);
        end else begin
          r_err <= 1'b1;
        end
      end

`ifdef SIMPLECPU_BREAKPOINT_EN
      if (w_wr && w_off == 3'd4) begin
        r_bp_addr <= wb.wbs_dat_i[PC_W-1:0];
        r_bp_ena  <= wb.wbs_dat_i[31];
      end
      if (cpu_clk_en_o) begin
        r_bp_skip <= 1'b0;
      end
`endif

      if (w_soft) begin
        r_state   <= ST_RST_HOLD;
        r_rst_cnt <= '0;
        r_rst     <= 1'b1;
        r_clk_en  <= 1'b0;
        r_err     <= 1'b0;
`ifdef SIMPLECPU_BREAKPOINT_EN
        r_bp_hit  <= 1'b0;
`endif
      end else begin
        case (r_state)
          ST_RST_HOLD: begin
            if (r_rst_cnt == CNT_W'(RST_CYCLES - 1)) begin
              r_state <= ST_IDLE;
              r_rst   <= 1'b0;
            end else begin
              r_rst_cnt <= r_rst_cnt + CNT_W'(1);
            end
          end
          ST_IDLE: begin
            if (w_ctrl_wr && !wb.wbs_dat_i[2] && !cpu_halted_i) begin
              if (wb.wbs_dat_i[0]) begin
                r_state  <= ST_RUN;
                r_clk_en <= 1'b1;
`ifdef SIMPLECPU_BREAKPOINT_EN
                r_bp_skip <= 1'b1;
`endif
              end else if (wb.wbs_dat_i[1]) begin
                r_state  <= ST_STEP;
                r_clk_en <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if ((w_ctrl_wr && wb.wbs_dat_i[2]) || w_run_stop) begin
              r_state  <= ST_IDLE;
              r_clk_en <= 1'b0;
              r_irq    <= 1'b1;
            end
`ifdef SIMPLECPU_BREAKPOINT_EN
            if (w_bp_now) begin
              r_bp_hit <= 1'b1;
            end
`endif
          end
          ST_STEP: begin
            r_state  <= ST_IDLE;
            r_clk_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wb.wbs_ack_o = r_ack;
  assign wb.wbs_dat_o = r_dat;
  assign cpu_rst_o    = r_rst;
  assign prog_we_o    = r_prog_we;
  assign prog_addr_o  = r_prog_addr;
  assign prog_data_o  = r_prog_data;
  assign irq_o        = r_irq;
endmodule

// File: tb/tb_simplecpu_wb_ctrl.sv
// Self-checking bench for simplecpu_wb_ctrl against a behavioural CPU and bus model.
// Breakpoint scenario depends on SIMPLECPU_BREAKPOINT_EN.
module tb_simplecpu_wb_ctrl;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [7:0]  O_CTRL = 8'h00;
  localparam logic [7:0]  O_STAT = 8'h04;
  localparam logic [7:0]  O_PROG = 8'h08;
  localparam logic [7:0]  O_PTR  = 8'h0C;
  localparam logic [7:0]  O_BP   = 8'h10;
  localparam logic [7:0]  O_CYC  = 8'h14;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  simplecpu_wb_ctrl_if wb();
  logic        cpu_rst, cpu_clk_en, prog_we, irq;
  logic [7:0]  prog_addr;
  logic [13:0] prog_data;
  logic [7:0]  cpu_pc = 8'd0;
  logic        cpu_halted = 1'b0;
  int          halt_pc = -1;

  int checks = 0;
  int failures = 0;

  simplecpu_wb_ctrl dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .wb           (wb),
    .cpu_rst_o    (cpu_rst),
    .cpu_clk_en_o (cpu_clk_en),
    .prog_we_o    (prog_we),
    .prog_addr_o  (prog_addr),
    .prog_data_o  (prog_data),
    .cpu_pc_i     (cpu_pc),
    .cpu_halted_i (cpu_halted),
    .irq_o        (irq)
  );

  // CPU model: one instruction per enabled cycle; executes HALT when it reaches halt_pc.
  always @(posedge clk) begin
    if (cpu_rst === 1'b1) begin
      cpu_pc     <= 8'd0;
      cpu_halted <= 1'b0;
    end else if (cpu_clk_en === 1'b1) begin
      cpu_pc <= cpu_pc + 8'd1;
      if (int'(cpu_pc) + 1 == halt_pc) cpu_halted <= 1'b1;
    end
  end

  int en_cnt = 0;
  int irq_cnt = 0;
  logic [22:0] pw_q[$];
  always @(negedge clk) begin
    if (cpu_clk_en === 1'b1) en_cnt <= en_cnt + 1;
    if (irq === 1'b1) irq_cnt <= irq_cnt + 1;
    if (prog_we === 1'b1) pw_q.push_back({wb.wbs_ack_o, prog_addr, prog_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  logic [31:0] rdata;
  int          lat;

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wd);
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_stb_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_adr_i = adr;
    wb.wbs_dat_i = wd;
    wb.wbs_sel_i = 4'hF;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (wb.wbs_ack_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    rdata = wb.wbs_dat_o;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    $display("wb %s adr=%h wdat=%h rdat=%h lat=%0d", we ? "WR" : "RD", adr, wd, rdata, lat);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    xfer(1'b1, BASE | 32'(off), d);
  endtask

  task automatic rd(input logic [7:0] off);
    xfer(1'b0, BASE | 32'(off), 32'h0);
  endtask

  function automatic logic [31:0] st(input logic [1:0] s, input logic h, input logic e,
                                     input logic b, input logic [7:0] pc);
    return {16'h0, pc, 3'b000, b, e, h, s};
  endfunction

  task automatic wait_irq(input int base, input int bound, input string name);
    int k = 0;
    while (irq_cnt == base && k < bound) begin
      tick();
      k++;
    end
    checks++;
    if (irq_cnt == base) begin
      failures++;
      $display("FAIL %s irq_wait got=no_irq_in_%0d_cycles exp=irq_pulse", name, bound);
    end
  endtask

  task automatic do_soft();
    wr(O_CTRL, 32'h8);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    int n;
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({wb.wbs_ack_o, wb.wbs_dat_o, cpu_rst, cpu_clk_en, prog_we, prog_addr, prog_data, irq} !==
        {1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 8'h0, 14'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs got=ack%b dat%h rst%b en%b we%b a%h d%h irq%b exp=0/0/1/0/0/0/0/0",
               wb.wbs_ack_o, wb.wbs_dat_o, cpu_rst, cpu_clk_en, prog_we, prog_addr, prog_data, irq);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && cpu_rst === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL reset_hold_cycles got=%0d exp=4", n); end
    rd(O_STAT);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL ack_latency got=%0d exp=1", lat); end
    checks++;
    if (rdata !== st(2'd1, 1'b0, 1'b0, 1'b0, 8'd0)) begin
      failures++; $display("FAIL status_after_reset got=%h exp=%h", rdata, st(2'd1, 1'b0, 1'b0, 1'b0, 8'd0));
    end
    rd(O_CYC);
    checks++;
    if (rdata !== 32'd0) begin failures++; $display("FAIL cycles_after_reset got=%h exp=0", rdata); end
  endtask

  task automatic test_prog_load();
    logic [22:0] exp_q[$];
    logic [22:0] got;
    logic [31:0] w;
    int ptr, n;
    wr(O_PTR, 32'hFE);
    pw_q.delete();
    wr(O_PROG, 32'h1ABC);
    wr(O_PROG, 32'h0123);
    wr(O_PROG, 32'h2222);
    tick();
    exp_q = '{ {1'b1, 8'hFE, 14'h1ABC}, {1'b1, 8'hFF, 14'h0123}, {1'b1, 8'h00, 14'h2222} };
    // Random loads from random pointers; expectations wrap modulo the 256-word program space.
    for (int r = 0; r < 4; r++) begin
      ptr = int'($urandom_range(0, 255));
      n = int'($urandom_range(1, 5));
      wr(O_PTR, 32'(ptr));
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        wr(O_PROG, w);
        exp_q.push_back({1'b1, 8'((ptr + i) % 256), w[13:0]});
      end
      rd(O_PTR);
      checks++;
      if (rdata !== 32'((ptr + n) % 256)) begin
        failures++; $display("FAIL loadptr_random got=%h exp=%h", rdata, 32'((ptr + n) % 256));
      end
    end
    checks++;
    if (pw_q.size() != exp_q.size()) begin
      failures++; $display("FAIL prog_we_count got=%0d exp=%0d", pw_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && pw_q.size() > 0) begin
      got = pw_q.pop_front();
      checks++;
      if (got !== exp_q[0]) begin
        failures++; $display("FAIL prog_write got=ack%b a%h d%h exp=ack%b a%h d%h",
                             got[22], got[21:14], got[13:0], exp_q[0][22], exp_q[0][21:14], exp_q[0][13:0]);
      end
      void'(exp_q.pop_front());
    end
    wr(O_PTR, 32'hFE);
    wr(O_PROG, 32'h1);
    wr(O_PROG, 32'h2);
    wr(O_PROG, 32'h3);
    rd(O_PTR);
    checks++;
    if (rdata !== 32'h01) begin failures++; $display("FAIL loadptr_wrap got=%h exp=01", rdata); end
  endtask

  task automatic test_run_halt();
    int e0, i0, hp;
    wr(O_CYC, 32'h0);
    e0 = en_cnt; i0 = irq_cnt; halt_pc = 10;
    wr(O_CTRL, 32'h1);
    wait_irq(i0, 200, "run_halt");
    repeat (3) tick();
    checks++;
    if (en_cnt - e0 != 10) begin failures++; $display("FAIL run_enabled_cycles got=%0d exp=10", en_cnt - e0); end
    checks++;
    if (irq_cnt - i0 != 1) begin failures++; $display("FAIL run_irq_cycles got=%0d exp=1", irq_cnt - i0); end
    rd(O_CYC);
    checks++;
    if (rdata !== 32'd10) begin failures++; $display("FAIL run_cycles got=%h exp=%h", rdata, 32'd10); end
    rd(O_STAT);
    checks++;
    if (rdata !== st(2'd1, 1'b1, 1'b0, 1'b0, 8'd10)) begin
      failures++; $display("FAIL run_halt_status got=%h exp=%h", rdata, st(2'd1, 1'b1, 1'b0, 1'b0, 8'd10));
    end
    e0 = en_cnt;
    wr(O_CTRL, 32'h1);
    wr(O_CTRL, 32'h2);
    repeat (3) tick();
    checks++;
    if (en_cnt != e0) begin failures++; $display("FAIL run_while_halted got=%0d exp=0", en_cnt - e0); end
    for (int r = 0; r < 3; r++) begin
      do_soft();
      hp = int'($urandom_range(2, 40));
      halt_pc = hp;
      wr(O_CYC, 32'h0);
      e0 = en_cnt; i0 = irq_cnt;
      wr(O_CTRL, 32'h1);
      wait_irq(i0, 200, "run_random");
      repeat (2) tick();
      rd(O_CYC);
      checks++;
      if (rdata !== 32'(hp)) begin failures++; $display("FAIL run_random_cycles got=%h exp=%h", rdata, 32'(hp)); end
      checks++;
      if (en_cnt - e0 != hp || cpu_pc !== 8'(hp)) begin
        failures++; $display("FAIL run_random_pc got=en%0d pc%0d exp=%0d", en_cnt - e0, cpu_pc, hp);
      end
    end
    halt_pc = -1;
  endtask

  task automatic test_step();
    int e0, i0;
    logic [31:0] c0;
    halt_pc = -1;
    do_soft();
    e0 = en_cnt;
    wr(O_CTRL, 32'h6);
    repeat (3) tick();
    checks++;
    if (en_cnt != e0) begin failures++; $display("FAIL halt_step_prio got=%0d exp=0", en_cnt - e0); end
    rd(O_CYC);
    c0 = rdata;
    e0 = en_cnt; i0 = irq_cnt;
    wr(O_CTRL, 32'h2);
    repeat (3) tick();
    checks++;
    if (en_cnt - e0 != 1 || irq_cnt != i0) begin
      failures++; $display("FAIL step_pulse got=en%0d irq%0d exp=en1 irq0", en_cnt - e0, irq_cnt - i0);
    end
    rd(O_CYC);
    checks++;
    if (rdata !== c0 + 32'd1) begin failures++; $display("FAIL step_cycles got=%h exp=%h", rdata, c0 + 32'd1); end
    rd(O_STAT);
    checks++;
    if (rdata !== st(2'd1, 1'b0, 1'b0, 1'b0, 8'd1)) begin
      failures++; $display("FAIL step_status got=%h exp=%h", rdata, st(2'd1, 1'b0, 1'b0, 1'b0, 8'd1));
    end
  endtask

  task automatic test_prog_in_run();
    int i0, n;
    halt_pc = -1;
    do_soft();
    wr(O_PTR, 32'h40);
    pw_q.delete();
    wr(O_CTRL, 32'h1);
    tick();
    wr(O_PROG, 32'h155);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL prog_in_run_ack got=%0d exp=1", lat); end
    tick();
    checks++;
    if (pw_q.size() != 0) begin failures++; $display("FAIL prog_in_run_we got=%0d exp=0", pw_q.size()); end
    rd(O_STAT);
    checks++;
    if (rdata[4:0] !== 5'b01010) begin failures++; $display("FAIL err_in_run got=%b exp=01010", rdata[4:0]); end
    i0 = irq_cnt;
    wr(O_CTRL, 32'h4);
    repeat (3) tick();
    checks++;
    if (irq_cnt - i0 != 1) begin failures++; $display("FAIL halt_cmd_irq got=%0d exp=1", irq_cnt - i0); end
    rd(O_PTR);
    checks++;
    if (rdata !== 32'h40) begin failures++; $display("FAIL ptr_after_drop got=%h exp=40", rdata); end
    wr(O_CTRL, 32'h8);
    n = 0;
    for (int i = 0; i < 20 && cpu_rst === 1'b1; i++) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL soft_reset_hold got=%0d exp=4", n); end
    rd(O_STAT);
    checks++;
    if (rdata !== st(2'd1, 1'b0, 1'b0, 1'b0, 8'd0)) begin
      failures++; $display("FAIL soft_reset_status got=%h exp=%h", rdata, st(2'd1, 1'b0, 1'b0, 1'b0, 8'd0));
    end
  endtask

  task automatic test_back_to_back();
    tick();
    rd(O_PTR);
    checks++;
    if (lat != 1 || rdata !== 32'h40) begin failures++; $display("FAIL b2b_first got=lat%0d %h exp=lat1 40", lat, rdata); end
    rd(O_PTR);
    checks++;
    if (lat != 2 || rdata !== 32'h40) begin failures++; $display("FAIL b2b_second got=lat%0d %h exp=lat2 40", lat, rdata); end
  endtask

  task automatic test_undecoded();
    int acks = 0;
    logic [7:0] offs [4] = '{8'h18, 8'h1C, 8'h38, 8'hFC};
    tick();
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = BASE + 32'h100;
    for (int i = 0; i < 6; i++) begin tick(); if (wb.wbs_ack_o === 1'b1) acks++; end
    wb.wbs_stb_i = 1'b0;
    wb.wbs_adr_i = BASE | 32'h4;
    for (int i = 0; i < 4; i++) begin tick(); if (wb.wbs_ack_o === 1'b1) acks++; end
    wb.wbs_cyc_i = 1'b0;
    checks++;
    if (acks != 0) begin failures++; $display("FAIL undecoded_ack got=%0d exp=0", acks); end
    for (int r = 0; r < 3; r++) begin
      tick();
      rd(offs[$urandom_range(0, 3)]);
      checks++;
      if (lat != 1 || rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=lat%0d %h exp=lat1 0", lat, rdata); end
    end
    rd(O_CTRL);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL ctrl_read got=%h exp=0", rdata); end
  endtask

  task automatic test_breakpoint();
`ifdef SIMPLECPU_BREAKPOINT_EN
    int e0, i0;
    halt_pc = -1;
    do_soft();
    wr(O_BP, 32'h8000_0005);
    rd(O_BP);
    checks++;
    if (rdata !== 32'h8000_0005) begin failures++; $display("FAIL bp_readback got=%h exp=80000005", rdata); end
    e0 = en_cnt; i0 = irq_cnt;
    wr(O_CTRL, 32'h1);
    wait_irq(i0, 100, "bp_hit");
    repeat (2) tick();
    checks++;
    if (cpu_pc !== 8'd5 || en_cnt - e0 != 5 || irq_cnt - i0 != 1) begin
      failures++; $display("FAIL bp_stop got=pc%0d en%0d irq%0d exp=pc5 en5 irq1", cpu_pc, en_cnt - e0, irq_cnt - i0);
    end
    rd(O_STAT);
    checks++;
    if (rdata !== st(2'd1, 1'b0, 1'b0, 1'b1, 8'd5)) begin
      failures++; $display("FAIL bp_status got=%h exp=%h", rdata, st(2'd1, 1'b0, 1'b0, 1'b1, 8'd5));
    end
    wr(O_CTRL, 32'h1);
    repeat (6) tick();
    wr(O_CTRL, 32'h4);
    repeat (2) tick();
    checks++;
    if (!(cpu_pc > 8'd5)) begin failures++; $display("FAIL bp_rerun got=pc%0d exp=pc>5", cpu_pc); end
`else
    wr(O_BP, 32'h8000_0005);
    rd(O_BP);
    checks++;
    if (rdata !== 32'h0) begin failures++; $display("FAIL bp_absent_read got=%h exp=0", rdata); end
    rd(O_STAT);
    checks++;
    if (rdata[4] !== 1'b0) begin failures++; $display("FAIL bp_absent_hit got=%b exp=0", rdata[4]); end
`endif
  endtask

  initial begin
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    wb.wbs_sel_i = 4'h0;
    wb.wbs_adr_i = 32'h0;
    wb.wbs_dat_i = 32'h0;
    test_reset();
    test_prog_load();
    test_run_halt();
    test_step();
    test_prog_in_run();
    test_back_to_back();
    test_undecoded();
    test_breakpoint();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
